// File: rtl/sal_hdr_cfg_if.sv
// APB slave bundle used by the header/DMA configuration block.
// It carries the 12-bit address and 32-bit data bus with zero-wait-state responses.
interface APB_IF;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport SLV (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

    modport MST (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );
endinterface

// File: rtl/sal_hdr_cfg.sv
// Per-channel packet header configuration with an APB register file and start/done handshake.
// Each channel owns a two-state transfer FSM, a done counter and one interrupt status bit.
module sal_hdr_cfg #(
    parameter int unsigned NUM_CH  = 4,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    APB_IF.SLV                    apb_if,
    output logic [NUM_CH*3-1:0]   hdr_fmt_o,
    output logic [NUM_CH*5-1:0]   hdr_type_o,
    output logic [NUM_CH*3-1:0]   hdr_tc_o,
    output logic [NUM_CH*9-1:0]   hdr_length_o,
    output logic [NUM_CH*16-1:0]  hdr_reqid_o,
    output logic [NUM_CH*16-1:0]  hdr_cplid_o,
    output logic [NUM_CH-1:0]     ch_start_o,
    input  logic [NUM_CH-1:0]     ch_done_i,
    output logic                  irq_o
);

    typedef enum logic {StIdle, StBusy} ch_state_e;

    logic                     access;
    logic                     wr_en;
    logic                     rd_en;
    logic                     is_id;
    logic                     is_stat;
    logic                     is_en;
    logic                     map_err;
    logic [1:0]               ch_off;
    logic [NUM_CH-1:0]        ch_sel;
    logic [NUM_CH-1:0]        ch_err;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        done_set;
    logic [NUM_CH-1:0]        w1c;
    logic [NUM_CH-1:0]        irq_stat_q;
    logic [NUM_CH-1:0]        irq_en_q;
    logic                     irq_q;
    logic [NUM_CH-1:0][31:0]  ch_rdata;
    logic [31:0]              rdata;

    assign access  = apb_if.psel & apb_if.penable;
    assign wr_en   = access & apb_if.pwrite;
    assign rd_en   = access & ~apb_if.pwrite;
    assign is_id   = (apb_if.paddr == 12'h000);
    assign is_stat = (apb_if.paddr == 12'h004);
    assign is_en   = (apb_if.paddr == 12'h008);
    assign ch_off  = apb_if.paddr[3:2];
    assign map_err = ~(is_id | is_stat | is_en | (|ch_sel));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e   state_q;
        logic        start_q;
        logic [2:0]  fmt_q;
        logic [4:0]  type_q;
        logic [2:0]  tc_q;
        logic [8:0]  length_q;
        logic [15:0] reqid_q;
        logic [15:0] cplid_q;
        logic [15:0] cnt_q;
        logic        ctrl_wr;
        logic        hdr0_we;
        logic        hdr1_we;
        logic        start_go;
        logic        abort_req;

        // Channel window: 0x100 + 0x20*c, four word registers in the low 16 bytes.
        assign ch_sel[c] = (apb_if.paddr[11:8] == 4'h1) && (apb_if.paddr[7:5] == 3'(c)) &&
                           !apb_if.paddr[4] && (apb_if.paddr[1:0] == 2'b00);
        assign busy[c]   = (state_q == StBusy);
        assign ctrl_wr   = wr_en & ch_sel[c] & (ch_off == 2'd2);
        assign hdr0_we   = wr_en & ch_sel[c] & (ch_off == 2'd0) & ~busy[c];
        assign hdr1_we   = wr_en & ch_sel[c] & (ch_off == 2'd1) & ~busy[c];
        assign abort_req = ctrl_wr & apb_if.pwdata[1];
        assign start_go  = ctrl_wr & apb_if.pwdata[0] & ~apb_if.pwdata[1] & ~busy[c];
        assign done_set[c] = busy[c] & ch_done_i[c];

        // Header and START writes are refused while a transfer is in flight.
        assign ch_err[c] = busy[c] & ((wr_en & ch_sel[c] & ~ch_off[1]) |
                                      (ctrl_wr & apb_if.pwdata[0] & ~apb_if.pwdata[1]));

        assign ch_rdata[c] =
            (ch_off == 2'd0) ? {7'd0, length_q, 5'd0, tc_q, type_q, fmt_q} :
            (ch_off == 2'd1) ? {cplid_q, reqid_q} :
            (ch_off == 2'd3) ? {cnt_q, 15'd0, busy[c]} : 32'd0;

        assign hdr_fmt_o[3*c +: 3]      = fmt_q;
        assign hdr_type_o[5*c +: 5]     = type_q;
        assign hdr_tc_o[3*c +: 3]       = tc_q;
        assign hdr_length_o[9*c +: 9]   = length_q;
        assign hdr_reqid_o[16*c +: 16]  = reqid_q;
        assign hdr_cplid_o[16*c +: 16]  = cplid_q;
        assign ch_start_o[c]            = start_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= StIdle;
                start_q  <= 1'b0;
                fmt_q    <= '0;
                type_q   <= '0;
                tc_q     <= '0;
                length_q <= '0;
                reqid_q  <= '0;
                cplid_q  <= '0;
                cnt_q    <= '0;
            end else begin
                start_q <= start_go;
                if (hdr0_we) begin
                    fmt_q    <= apb_if.pwdata[2:0];
                    type_q   <= apb_if.pwdata[7:3];
                    tc_q     <= apb_if.pwdata[10:8];
                    length_q <= apb_if.pwdata[24:16];
                end
                if (hdr1_we) begin
                    reqid_q <= apb_if.pwdata[15:0];
                    cplid_q <= apb_if.pwdata[31:16];
                end
                case (state_q)
                    StIdle: begin
                        if (start_go) state_q <= StBusy;
                    end
                    StBusy: begin
                        // A completion in the same cycle as ABORT still counts as done.
                        if (ch_done_i[c]) begin
                            state_q <= StIdle;
                            cnt_q   <= cnt_q + 16'd1;
                        end else if (abort_req) begin
                            state_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign w1c = (wr_en & is_stat) ? apb_if.pwdata[NUM_CH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~w1c) | done_set;
            if (wr_en & is_en) irq_en_q <= apb_if.pwdata[NUM_CH-1:0];
            irq_q <= |(irq_stat_q & irq_en_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (is_id) begin
            rdata = VERSION;
        end else if (is_stat) begin
            rdata[NUM_CH-1:0] = irq_stat_q;
        end else if (is_en) begin
            rdata[NUM_CH-1:0] = irq_en_q;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) rdata = ch_rdata[c];
        end
    end

    assign apb_if.prdata  = (rd_en & ~map_err) ? rdata : 32'd0;
    assign apb_if.pready  = 1'b1;
    assign apb_if.pslverr = access & (map_err | (|ch_err));
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_sal_hdr_cfg.sv
// Bench for sal_hdr_cfg: directed vector table, hand sequences and random traffic
// checked against an array-based register/transfer model.
module tb_sal_hdr_cfg;
    localparam logic [31:0] VER       = 32'h0002_0000;
    localparam logic [31:0] HDR0_MASK = 32'h01FF_07FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    APB_IF bus ();
    APB_IF bus2 ();

    logic [11:0] fmt, tc;
    logic [19:0] typ;
    logic [35:0] len;
    logic [63:0] reqid, cplid;
    logic [3:0]  start, done;
    logic        irq;

    logic [5:0]  fmt2, tc2;
    logic [9:0]  typ2;
    logic [17:0] len2;
    logic [31:0] reqid2, cplid2;
    logic [1:0]  start2, done2;
    logic        irq2;

    sal_hdr_cfg #(.NUM_CH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .apb_if(bus),
        .hdr_fmt_o(fmt), .hdr_type_o(typ), .hdr_tc_o(tc), .hdr_length_o(len),
        .hdr_reqid_o(reqid), .hdr_cplid_o(cplid),
        .ch_start_o(start), .ch_done_i(done), .irq_o(irq)
    );

    sal_hdr_cfg #(.NUM_CH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .apb_if(bus2),
        .hdr_fmt_o(fmt2), .hdr_type_o(typ2), .hdr_tc_o(tc2), .hdr_length_o(len2),
        .hdr_reqid_o(reqid2), .hdr_cplid_o(cplid2),
        .ch_start_o(start2), .ch_done_i(done2), .irq_o(irq2)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_hdr0 [4];
    logic [31:0] m_hdr1 [4];
    int          m_cnt  [4];
    logic [3:0]  m_busy, m_stat, m_en, start_exp;

    typedef struct {
        logic [11:0] addr;
        bit          wr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_hdr0[c] = 0;
            m_hdr1[c] = 0;
            m_cnt[c]  = 0;
        end
        m_busy = 0; m_stat = 0; m_en = 0; start_exp = 0;
    endtask

    task automatic model_done(input logic [3:0] dn);
        for (int c = 0; c < 4; c++) begin
            if (m_busy[c] && dn[c]) begin
                m_busy[c] = 1'b0;
                m_cnt[c]  = (m_cnt[c] + 1) % 65536;
                m_stat[c] = 1'b1;
            end
        end
    endtask

    task automatic model_access(input logic [11:0] a, input bit w, input logic [31:0] d,
                                input logic [3:0] dn, output logic [31:0] rd, output bit err);
        int ai, ch, off;
        bit start_ok, abort;
        ai = int'(a);
        rd = 0; err = 0; ch = -1; off = 0; start_ok = 0; abort = 0;
        if (ai == 0) rd = VER;
        else if (ai == 4) rd = {28'd0, m_stat};
        else if (ai == 8) rd = {28'd0, m_en};
        else if (ai >= 'h100 && ai < 'h180 && (ai - 'h100) % 'h20 <= 'hC && ai % 4 == 0) begin
            ch  = (ai - 'h100) / 'h20;
            off = (ai - 'h100) % 'h20;
        end else err = 1;
        if (ch >= 0) begin
            case (off)
                0: if (!w) rd = m_hdr0[ch];
                   else if (m_busy[ch]) err = 1;
                   else m_hdr0[ch] = d & HDR0_MASK;
                4: if (!w) rd = m_hdr1[ch];
                   else if (m_busy[ch]) err = 1;
                   else m_hdr1[ch] = d;
                8: if (w) begin
                       if (d[1]) abort = 1;
                       else if (d[0]) begin
                           if (m_busy[ch]) err = 1; else start_ok = 1;
                       end
                   end
                default: if (!w) rd = {m_cnt[ch][15:0], 15'd0, m_busy[ch]};
            endcase
        end
        if (w || err) rd = 0;
        if (w && ai == 4) m_stat = m_stat & ~d[3:0];
        if (w && ai == 8) m_en = d[3:0];
        model_done(dn);
        if (abort) m_busy[ch] = 1'b0;
        if (start_ok) begin
            m_busy[ch]    = 1'b1;
            start_exp[ch] = 1'b1;
        end
    endtask

    task automatic tick(input bit pend);
        logic [11:0] ef, et;
        logic [19:0] ety;
        logic [35:0] el;
        logic [63:0] er, ec;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            ef[3*c +: 3]    = m_hdr0[c][2:0];
            ety[5*c +: 5]   = m_hdr0[c][7:3];
            et[3*c +: 3]    = m_hdr0[c][10:8];
            el[9*c +: 9]    = m_hdr0[c][24:16];
            er[16*c +: 16]  = m_hdr1[c][15:0];
            ec[16*c +: 16]  = m_hdr1[c][31:16];
        end
        chk("ch_start", start, start_exp);
        start_exp = 0;
        chk("irq", irq, pend);
        chk("hdr_fmt", fmt, ef);
        chk("hdr_type", typ, ety);
        chk("hdr_tc", tc, et);
        chk("hdr_length", len, el);
        chk("hdr_reqid", reqid, er);
        chk("hdr_cplid", cplid, ec);
    endtask

    task automatic apb(input logic [11:0] a, input bit w, input logic [31:0] d,
                       input logic [3:0] dn, output logic [31:0] rd, output logic err);
        logic [31:0] erd;
        bit eerr, pend;
        bus.psel = 1; bus.penable = 0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
        #1;
        chk("setup_prdata", bus.prdata, 0);
        chk("setup_pslverr", bus.pslverr, 0);
        tick(|(m_stat & m_en));
        bus.penable = 1; done = dn;
        #1;
        rd = bus.prdata; err = bus.pslverr;
        pend = |(m_stat & m_en);
        model_access(a, w, d, dn, erd, eerr);
        chk($sformatf("prdata@%h", a), rd, erd);
        chk($sformatf("pslverr@%h", a), err, eerr);
        tick(pend);
        bus.psel = 0; bus.penable = 0; done = 0;
    endtask

    task automatic idle_cycle(input logic [3:0] dn);
        bit pend;
        done = dn;
        pend = |(m_stat & m_en);
        model_done(dn);
        tick(pend);
        done = 0;
    endtask

    task automatic apb2(input logic [11:0] a, input bit w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err);
        bus2.psel = 1; bus2.penable = 0; bus2.pwrite = w; bus2.paddr = a; bus2.pwdata = d;
        @(posedge clk); #1;
        bus2.penable = 1;
        #1;
        rd = bus2.prdata; err = bus2.pslverr;
        @(posedge clk); #1;
        bus2.psel = 0; bus2.penable = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fmt"}, fmt, 0);
        chk({tag, "_type"}, typ, 0);
        chk({tag, "_tc"}, tc, 0);
        chk({tag, "_len"}, len, 0);
        chk({tag, "_reqid"}, reqid, 0);
        chk({tag, "_cplid"}, cplid, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_prdata"}, bus.prdata, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [11:0] a;
        logic [31:0] d;
        logic [11:0] bad_addr [6];
        bad_addr = '{12'h00C, 12'h010, 12'h180, 12'h110, 12'h102, 12'hFFC};

        vecs[0]  = '{12'h000, 0, 32'h0,          VER,            0};
        vecs[1]  = '{12'h004, 0, 32'h0,          32'h0,          0};
        vecs[2]  = '{12'h008, 0, 32'h0,          32'h0,          0};
        vecs[3]  = '{12'h10C, 0, 32'h0,          32'h0,          0};
        vecs[4]  = '{12'h120, 1, 32'h0120_0544,  32'h0,          0};
        vecs[5]  = '{12'h120, 0, 32'h0,          32'h0120_0544,  0};
        vecs[6]  = '{12'h124, 1, 32'hBEEF_1234,  32'h0,          0};
        vecs[7]  = '{12'h124, 0, 32'h0,          32'hBEEF_1234,  0};
        vecs[8]  = '{12'h128, 0, 32'h0,          32'h0,          0};
        vecs[9]  = '{12'h180, 0, 32'h0,          32'h0,          1};
        vecs[10] = '{12'h00C, 1, 32'h1234,       32'h0,          1};
        vecs[11] = '{12'h130, 1, 32'h1,          32'h0,          1};
        vecs[12] = '{12'h008, 1, 32'hFFFF_FFFF,  32'h0,          0};
        vecs[13] = '{12'h008, 0, 32'h0,          32'hF,          0};
        vecs[14] = '{12'h160, 1, 32'hFFFF_FFFF,  32'h0,          0};
        vecs[15] = '{12'h160, 0, 32'h0,          32'h01FF_07FF,  0};
        vecs[16] = '{12'h008, 1, 32'h0,          32'h0,          0};

        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
        bus2.psel = 0; bus2.penable = 0; bus2.pwrite = 0; bus2.paddr = 0; bus2.pwdata = 0;
        done = 0; done2 = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        chk("pready", bus.pready, 1);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Directed register table
        for (int i = 0; i < 17; i++) begin
            apb(vecs[i].addr, vecs[i].wr, vecs[i].data, 4'd0, rd, err);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end
        chk("ch1_fmt", fmt[5:3], 3'b100);
        chk("ch1_type", typ[9:5], 5'b01000);
        chk("ch1_tc", tc[5:3], 3'b101);
        chk("ch1_len", len[17:9], 9'h120);

        // Start, busy lockout, done
        apb(12'h108, 1, 32'h1, 4'd0, rd, err);
        chk("start_pulse", start, 4'b0001);
        apb(12'h10C, 0, 0, 4'd0, rd, err);
        chk("busy_status", rd, 32'h1);
        apb(12'h100, 1, 32'h7, 4'd0, rd, err);
        chk("busy_hdr_err", err, 1);
        chk("busy_hdr_kept", fmt[2:0], 3'b000);
        idle_cycle(4'b0001);
        apb(12'h10C, 0, 0, 4'd0, rd, err);
        chk("done_status", rd, 32'h0001_0000);
        apb(12'h004, 0, 0, 4'd0, rd, err);
        chk("done_stat", rd, 32'h1);

        // Interrupt enable, W1C, W1C racing a new done
        apb(12'h008, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'd0);
        chk("irq_on", irq, 1);
        apb(12'h004, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'd0);
        chk("irq_off", irq, 0);
        apb(12'h108, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'b0001);
        apb(12'h108, 1, 32'h1, 4'd0, rd, err);
        apb(12'h004, 1, 32'h1, 4'b0001, rd, err);
        apb(12'h004, 0, 0, 4'd0, rd, err);
        chk("w1c_vs_done", rd, 32'h1);

        // START+ABORT together while idle: abort wins, no error
        apb(12'h128, 1, 32'h3, 4'd0, rd, err);
        chk("start_abort_err", err, 0);
        chk("start_abort_pulse", start, 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            int s;
            logic [3:0] dn;
            s = $urandom_range(0, 19);
            if (s < 3) a = 12'(4 * s);
            else if (s < 17) a = 12'(32'h100 + 32'h20 * $urandom_range(0, 3) + 4 * $urandom_range(0, 3));
            else a = bad_addr[$urandom_range(0, 5)];
            d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 3)) : $urandom;
            dn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            apb(a, 1'($urandom_range(0, 1)), d, dn, rd, err);
        end

        // Second instance with two channels: out-of-range and unmapped accesses
        apb2(12'h140, 0, 0, rd, err);
        chk("nc2_rd_err", err, 1);
        chk("nc2_rd_data", rd, 0);
        apb2(12'h010, 1, 32'hFFFF_FFFF, rd, err);
        chk("nc2_wr_err", err, 1);
        done2 = 2'b10;
        @(posedge clk); #1;
        done2 = 0;
        apb2(12'h12C, 0, 0, rd, err);
        chk("nc2_idle_done_status", rd, 0);
        apb2(12'h004, 0, 0, rd, err);
        chk("nc2_idle_done_stat", rd, 0);
        chk("nc2_irq", irq2, 0);
        chk("nc2_start", start2, 0);

        // Reset in the middle of a transfer
        for (int c = 0; c < 4; c++) apb(12'(32'h108 + 32'h20 * c), 1, 32'h2, 4'd0, rd, err);
        apb(12'h008, 1, 32'hF, 4'd0, rd, err);
        apb(12'h108, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'b0001);
        apb(12'h140, 1, 32'h01FF_07FF, 4'd0, rd, err);
        apb(12'h148, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'd0);
        chk("pre_rst_irq", irq, 1);
        chk("pre_rst_fmt", fmt[8:6], 3'b111);
        #2 rst_n = 0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        model_reset();
        apb(12'h14C, 0, 0, 4'd0, rd, err);
        chk("post_rst_status", rd, 0);
        apb(12'h004, 0, 0, 4'd0, rd, err);
        chk("post_rst_stat", rd, 0);

        // 65536 start/done cycles on channel 3: counter wraps
        for (int i = 0; i < 65535; i++) begin
            bus.psel = 1; bus.penable = 1; bus.pwrite = 1; bus.paddr = 12'h168; bus.pwdata = 1;
            done = 0;
            @(posedge clk); #1;
            bus.pwrite = 0; bus.paddr = 12'h16C; done = 4'b1000;
            @(posedge clk); #1;
        end
        bus.psel = 0; bus.penable = 0; done = 0;
        m_cnt[3] = 65535; m_stat[3] = 1'b1;
        apb(12'h16C, 0, 0, 4'd0, rd, err);
        chk("cnt_ffff", rd, 32'hFFFF_0000);
        apb(12'h168, 1, 32'h1, 4'd0, rd, err);
        idle_cycle(4'b1000);
        apb(12'h16C, 0, 0, 4'd0, rd, err);
        chk("cnt_wrap", rd, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sal_hdr_cfg.md
SAL_HDR_CFG -- requirements
Module: sal_hdr_cfg

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, legal range 1..8, giving the number of independent header/DMA channels.
REQ-002 SHALL have parameter VERSION, default 32'h0002_0000, the value returned by the ID register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port apb_if, APB_IF.SLV modport, using psel, penable, pwrite, paddr[11:0], pwdata[31:0], prdata[31:0], pready and pslverr.
REQ-006 SHALL have port hdr_fmt_o, output, NUM_CH*3 bits: packed per-channel fmt, channel c at [3c+2:3c].
REQ-007 SHALL have port hdr_type_o, output, NUM_CH*5 bits: packed per-channel type.
REQ-008 SHALL have port hdr_tc_o, output, NUM_CH*3 bits: packed per-channel traffic class.
REQ-009 SHALL have port hdr_length_o, output, NUM_CH*9 bits: packed per-channel length.
REQ-010 SHALL have port hdr_reqid_o, output, NUM_CH*16 bits: packed per-channel requester ID.
REQ-011 SHALL have port hdr_cplid_o, output, NUM_CH*16 bits: packed per-channel completer ID.
REQ-012 SHALL have port ch_start_o, output, NUM_CH bits: one-cycle start pulse per channel.
REQ-013 SHALL have port ch_done_i, input, NUM_CH bits: one-cycle completion pulse from the engine.
REQ-014 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-015 SHALL define an access as psel & penable; pready SHALL be tied to 1 (zero wait states).
REQ-016 SHALL use this global map: 0x000 ID (RO, returns VERSION); 0x004 IRQ_STAT (RO bits with W1C, one bit per channel); 0x008 IRQ_EN (RW, NUM_CH bits).
REQ-017 SHALL place channel c registers at base 0x100+0x20*c, for c < NUM_CH.
REQ-018 SHALL map channel offset +0x00 as HDR0 (RW): fmt[2:0], type[7:3], tc[10:8], length[24:16]; all other bits reserved, read 0.
REQ-019 SHALL map channel offset +0x04 as HDR1 (RW): reqid[15:0], cplid[31:16].
REQ-020 SHALL map channel offset +0x08 as CTRL (WO, reads 0): bit0 START, bit1 ABORT.
REQ-021 SHALL map channel offset +0x0C as STATUS (RO): bit0 BUSY, bits[31:16] count of completed transfers.
REQ-022 SHALL drive prdata combinationally during a read access and 0 at all other times.
REQ-023 SHALL treat unmapped addresses, including channel indices >= NUM_CH, as errors: pslverr=1 in the access cycle, writes ignored, reads return 0.
REQ-024 SHALL run a per-channel FSM with states IDLE and BUSY.
REQ-025 SHALL move IDLE->BUSY on a START write; ch_start_o[c] SHALL pulse high for exactly the cycle after the access.
REQ-026 SHALL move BUSY->IDLE on ch_done_i[c] or on an ABORT write.
REQ-027 On a done-triggered exit, SHALL set IRQ_STAT[c] and increment the done count, which wraps 0xFFFF->0.
REQ-028 On an ABORT-triggered exit, SHALL leave IRQ_STAT[c] and the done count unchanged.
REQ-029 While BUSY, SHALL ignore HDR0/HDR1/START writes to that channel and return pslverr=1, so header outputs stay stable for the whole transfer.
REQ-030 SHALL ignore ch_done_i[c] while IDLE.
REQ-031 If START and ABORT are written together while IDLE, SHALL give ABORT priority: no start pulse, no error.
REQ-032 If a ch_done_i[c] pulse and an IRQ_STAT W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-033 SHALL drive irq_o registered as |(IRQ_STAT & IRQ_EN).
REQ-034 SHALL drive header outputs directly from the HDR registers.

Reset
REQ-035 On rst_n low, SHALL asynchronously clear all registers: HDR fields 0, IRQ_STAT 0, IRQ_EN 0, done counts 0, all FSMs IDLE, ch_start_o 0, irq_o 0.
REQ-036 SHALL make reset mid-transfer return the channel to IDLE with no start pulse and no interrupt.

Verification
REQ-037 Write ch1 HDR0=0x0120_0544, then read -> hdr_fmt ch1=3'b100, type=5'b01000, tc=3'b101, length=9'h120, read data 0x0120_0544.
REQ-038 Write ch0 CTRL=0x1 -> ch_start_o[0] high 1 cycle, STATUS BUSY=1; HDR0 write now gives pslverr=1 with outputs unchanged; ch_done_i[0] pulse -> BUSY=0, count=1, IRQ_STAT=0x1.
REQ-039 With IRQ_EN=0x1 after a done -> irq_o=1 on the next cycle; write IRQ_STAT=0x1 -> irq_o=0; W1C coinciding with a new done -> bit stays 1.
REQ-040 With NUM_CH=2, read 0x140 and write 0x010 -> pslverr=1 with prdata=0; a ch_done_i[1] pulse while idle -> no state change.
REQ-041 START ch2, then assert rst_n low mid-BUSY -> all outputs 0 immediately with no clock edge; after release, BUSY=0 and IRQ_STAT=0.
REQ-042 Issue 65536 start/done cycles on ch3 -> done count wraps to 0x0000.
